// File: rtl/alert_annunciator_pkg.sv
// Shared state encoding for the alert path (alert latch and annunciator).
package alert_annunciator_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 2'd0,
      ST_ALARM    = 2'd1,
      ST_SILENCED = 2'd2,
      ST_ILLEGAL  = 2'd3
   } state_t;

endpackage

// File: rtl/alert_annunciator_if.sv
// Alert/acknowledge handshake and alarm indications between the board and the annunciator.
interface alert_annunciator_if #(
   parameter int unsigned CNT_W = 4
) ();

   logic             alert;
   logic             ack;
   logic             buzzer;
   logic             led;
   logic             ack_taken;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] alarm_count;

   // Board side: drives the alert level and button, observes the alarm.
   modport master (
      output alert, ack,
      input  buzzer, led, ack_taken, state_o, alarm_count
   );

   // Annunciator side.
   modport slave (
      input  alert, ack,
      output buzzer, led, ack_taken, state_o, alarm_count
   );

endinterface

// File: rtl/alert_annunciator_blink_divider.sv
// Square-wave generator for the buzzer: BLINK_DIV cycles high, BLINK_DIV cycles low.
module blink_divider #(
   parameter int unsigned BLINK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic out
);

   localparam int unsigned      PH_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(BLINK_DIV - 1);

   logic [PH_W-1:0] phase;

   // Held at phase 0 / high while disabled so each enable starts with a full high phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
         out   <= 1'b1;
      end else if (!en) begin
         phase <= '0;
         out   <= 1'b1;
      end else if (phase == PH_LAST) begin
         phase <= '0;
         out   <= ~out;
      end else begin
         phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/alert_annunciator.sv
// Alarm annunciator: turns the latched alert level into buzzer/LED drive with an
// operator acknowledge handshake and a saturating count of alarm entries.
module alert_annunciator
   import alert_annunciator_pkg::*;
#(
   parameter int unsigned BLINK_DIV = 4,
   parameter int unsigned MIN_ON    = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   alert_annunciator_if.slave   bus
);

   localparam int unsigned       ON_W    = $clog2(MIN_ON + 1);
   localparam logic [ON_W-1:0]   ON_MAX  = ON_W'(MIN_ON);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   state_t           state;
   logic             ack_d;
   logic             ack_edge;
   logic [ON_W-1:0]  on_timer;
   logic             led_q;
   logic             ack_taken_q;
   logic [CNT_W-1:0] count_q;
   logic             blink_out;

   assign ack_edge = bus.ack & ~ack_d;

   blink_divider #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk (clk),
      .rst (rst),
      .en  (state == ST_ALARM),
      .out (blink_out)
   );

   // FSM with ack edge detect, minimum-on timer and saturating entry counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         ack_d       <= 1'b1;
         on_timer    <= '0;
         led_q       <= 1'b0;
         ack_taken_q <= 1'b0;
         count_q     <= '0;
      end else begin
         ack_d       <= bus.ack;
         ack_taken_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               led_q <= 1'b0;
               // An ack edge arriving together with the alert is simply dropped.
               if (bus.alert) begin
                  state    <= ST_ALARM;
                  led_q    <= 1'b1;
                  on_timer <= '0;
                  if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
               end
            end
            ST_ALARM: begin
               led_q <= 1'b1;
               if (on_timer != ON_MAX) on_timer <= on_timer + 1'b1;
               // The alert dropping does not end the alarm; only an accepted ack does.
               if (ack_edge && (on_timer == ON_MAX)) begin
                  state       <= ST_SILENCED;
                  ack_taken_q <= 1'b1;
               end
            end
            ST_SILENCED: begin
               led_q <= 1'b1;
               if (!bus.alert) begin
                  state <= ST_IDLE;
                  led_q <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               led_q <= 1'b0;
            end
         endcase
      end
   end

   // Both operands are flops, so the buzzer only moves just after a clock edge
   // and drops at once on async reset.
   assign bus.buzzer      = blink_out & (state == ST_ALARM);
   assign bus.led         = led_q;
   assign bus.ack_taken   = ack_taken_q;
   assign bus.state_o     = state;
   assign bus.alarm_count = count_q;

endmodule
